rr_req_dispatcher: RTL
======================

// Module: rr_req_dispatcher
// PURPOSE
//  Requester-side companion of round_robin: queues per-requester request pulses and drives the arbiter's req/en inputs.
//  Consumes the arbiter's one-hot grant and hands the winning index downstream over a valid/ready handshake.
//  Sits between N client ports and round_robin; shares clock and reset with the arbiter.
// PARAMETERS
//  N      10             number of requesters; must match round_robin N
//  CNT_W  4              width of each per-requester pending counter; saturates at 2**CNT_W-1
//  M      $clog2(N)      localparam, width of o_idx
// PORTS
//  i_clk        in   1      clock, all logic on rising edge
//  i_rstn       in   1      reset; synchronous, active-high (1 = reset)
//  i_req_pulse  in   N      per-requester request strobe; +1 pending per asserted bit per cycle
//  o_req        out  N      request vector to arbiter; frozen pending mask
//  o_en         out  1      arbitration enable to arbiter
//  i_gnt        in   N      registered one-hot grant from arbiter
//  o_valid      out  1      granted index available
//  i_ready      in   1      downstream accepts o_idx when o_valid&i_ready
//  o_idx        out  M      index of granted requester
//  o_pending    out  N      bit i = counter i nonzero (live)
//  o_err        out  1      sticky: illegal grant or counter saturation overflow
// BEHAVIOUR
//  Reset: o_req=0, o_en=0, o_valid=0, o_idx=0, o_err=0, all counters=0, FSM=IDLE; pending requests discarded.
//  Reset mid-operation aborts any in-flight grant.
//  FSM (one arbitration in flight at a time):
//   IDLE: if |o_pending -> ARB, else stay.
//   ARB:  o_en=1 for exactly one cycle; o_req=req_q, where req_q is the pending mask latched on IDLE->ARB.
//         req_q is held until the grant is consumed; next -> GNT.
//   GNT:  sample i_gnt (arbiter updated it on the edge ending ARB).
//         Legal grant (see CONFIGURATION): o_idx<=index, decrement that counter, -> SEND.
//         Otherwise: o_err<=1, no decrement, -> IDLE.
//   SEND: o_valid=1, o_idx stable until i_ready. On handshake: if |o_pending -> ARB (back-to-back), else -> IDLE.
//  o_req=req_q in ARB/GNT only, 0 elsewhere. o_en=1 only in ARB.
//  Latency: pulse at cycle t -> o_en at t+2 -> grant sampled t+3 -> o_valid at t+4 (idle system).
//  Throughput: max one grant per 3 cycles with i_ready held high.
//  Counters:
//   Increment and decrement of the same counter in one cycle -> net unchanged.
//   Increment at max value -> stays at max, o_err<=1.
//   Decrement only occurs on a counter with a latched nonzero value, so no underflow.
//  Pulses arriving during ARB/GNT/SEND are counted; they do not alter req_q.
// CONFIGURATION
//  RR_DISP_GNT_CHECK_EN defined:
//   Legal grant = i_gnt one-hot AND (i_gnt & ~req_q)==0.
//   Zero-hot, multi-hot or unrequested grant sets o_err and returns to IDLE.
//  RR_DISP_GNT_CHECK_EN undefined:
//   Lowest set bit of (i_gnt & req_q) is taken as winner; if that is zero -> IDLE silently.
//   No grant checking; o_err flags overflow only.
// STRUCTURE
//  Package rr_pkg: typedef enum logic[1:0] {IDLE,ARB,GNT,SEND} rr_disp_state_t;
//   function is_onehot(); function onehot_to_idx() (parameterised by N via let or class-static).
//  Sub-module rr_req_counter (CNT_W): saturating up/down counter with inc/dec/nonzero/ovf.
//   N instances via generate.
// TESTING (N=4, CNT_W=2, bench pairs DUT with round_robin TYPE=1 unless noted)
//  1 Reset: hold i_rstn=1 3 cycles with i_req_pulse=4'b1111 -> counters 0, o_valid=0, o_en=0, o_err=0.
//  2 Single pulse i_req_pulse=4'b0100 at t, i_ready=1 -> o_en=1 at t+2, o_valid=1 with o_idx=2 at t+4, o_pending=0 after.
//  3 Pulse 4'b1111 once, i_ready=1 -> o_idx sequence 0,1,2,3 (rotating from ptr 0), grants 3 cycles apart, then IDLE.
//  4 Backpressure: pending on 1, i_ready=0 for 5 cycles -> o_valid held, o_idx=1 stable, no further o_en; handshake -> IDLE.
//  5 Saturation: 4 pulses on bit 0 with i_ready=0 -> counter stays 3, o_err=1; three grants to idx 0 follow.
//  6 Grant check (macro on, stub arbiter): i_gnt=4'b0011 in GNT -> o_err=1, no o_valid, counters unchanged.
//    Macro off, same stimulus -> o_idx=0, o_err=0.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin request dispatcher.
// The grant-check build option (RR_DISP_GNT_CHECK_EN) is consumed by rr_req_dispatcher.
package rr_pkg;

  typedef enum logic [1:0] {IDLE, ARB, GNT, SEND} rr_disp_state_t;

  // Helpers operate on a fixed-width vector; callers zero-extend their N-bit vectors.
  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [RR_MAX_N-1:0] v);
    return (v != '0) && ((v & (v - RR_MAX_N'(1))) == '0);
  endfunction

  // Index of the lowest set bit; for a one-hot vector this is its position.
  function automatic logic [RR_IDX_W-1:0] onehot_to_idx(input logic [RR_MAX_N-1:0] v);
    logic [RR_IDX_W-1:0] r;
    r = '0;
    for (int i = RR_MAX_N - 1; i >= 0; i--) begin
      if (v[i]) r = RR_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_req_dispatcher_counter.sv
// Saturating up/down pending-request counter (rr_req_counter), one per requester.
module rr_req_counter #(
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  // Count up on inc, down on dec; simultaneous inc/dec cancels, increments saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        2'b01:   if (cnt != '0)      cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign nonzero = (cnt != '0);
  // Lost increment: arrived at max with no decrement to absorb it.
  assign ovf     = inc & ~dec & (cnt == CNT_MAX);

endmodule

// File: rtl/rr_req_dispatcher.sv
// Requester-side companion of round_robin: counts request pulses per client,
// drives the arbiter's req/en, consumes its one-hot grant and hands the winning
// index downstream.
// Build option: RR_DISP_GNT_CHECK_EN enables strict grant checking (zero-hot,
// multi-hot or unrequested grants raise o_err); without it the lowest requested
// grant bit wins and an empty grant is dropped silently.
//
// Handshake: o_idx is transferred on a cycle where o_valid && i_ready; once
// o_valid rises, o_valid and o_idx hold unchanged until that transfer.
module rr_req_dispatcher
  import rr_pkg::*;
#(
  parameter  int N     = 10,
  parameter  int CNT_W = 4,
  localparam int M     = $clog2(N)
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [N-1:0]   i_req_pulse,
  output logic [N-1:0]   o_req,
  output logic           o_en,
  input  logic [N-1:0]   i_gnt,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [M-1:0]   o_idx,
  output logic [N-1:0]   o_pending,
  output logic           o_err,
  output rr_disp_state_t o_state
);

  rr_disp_state_t state, state_next;
  logic [N-1:0]   req_q;
  logic [N-1:0]   dec_vec;
  logic [N-1:0]   ovf_vec;
  logic [N-1:0]   gnt_win;
  logic           gnt_legal;
  logic           latch_req;
  logic           grant_ok;
  logic           grant_bad;
  logic           gnt_check_err;

  // Per-requester pending counters.
  for (genvar g = 0; g < N; g++) begin : g_cnt
    rr_req_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (i_clk),
      .rst     (i_rstn),
      .inc     (i_req_pulse[g]),
      .dec     (dec_vec[g]),
      .nonzero (o_pending[g]),
      .ovf     (ovf_vec[g])
    );
  end

`ifdef RR_DISP_GNT_CHECK_EN
  // Strict: exactly one bit, and only among the requesters that were offered.
  assign gnt_legal     = is_onehot(RR_MAX_N'(i_gnt)) && ((i_gnt & ~req_q) == '0);
  assign gnt_win       = i_gnt;
  assign gnt_check_err = 1'b1;
`else
  // Lenient: keep the lowest requested grant bit, ignore everything else.
  logic [N-1:0] gnt_cand;
  assign gnt_cand      = i_gnt & req_q;
  assign gnt_win       = gnt_cand & (~gnt_cand + N'(1));
  assign gnt_legal     = |gnt_cand;
  assign gnt_check_err = 1'b0;
`endif

  assign dec_vec = grant_ok ? gnt_win : '0;

  // Next-state logic: one arbitration in flight at a time.
  always_comb begin
    state_next = state;
    latch_req  = 1'b0;
    grant_ok   = 1'b0;
    grant_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (|o_pending) begin
          state_next = ARB;
          latch_req  = 1'b1;
        end
      end
      ARB: state_next = GNT;
      GNT: begin
        if (gnt_legal) begin
          state_next = SEND;
          grant_ok   = 1'b1;
        end else begin
          state_next = IDLE;
          grant_bad  = 1'b1;
        end
      end
      SEND: begin
        if (i_ready) begin
          if (|o_pending) begin
            state_next = ARB;
            latch_req  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, frozen request mask, granted index and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      state <= IDLE;
      req_q <= '0;
      o_idx <= '0;
      o_err <= 1'b0;
    end else begin
      state <= state_next;
      if (latch_req) req_q <= o_pending;
      if (grant_ok)  o_idx <= M'(onehot_to_idx(RR_MAX_N'(gnt_win)));
      if ((|ovf_vec) || (grant_bad && gnt_check_err)) o_err <= 1'b1;
    end
  end

  assign o_en    = (state == ARB);
  assign o_req   = ((state == ARB) || (state == GNT)) ? req_q : '0;
  assign o_valid = (state == SEND);
  assign o_state = state;

endmodule
